// File: rtl/pd_pkg.sv
// Shared types, widths and saturation helpers for the PD axis scheduler.
package pd_pkg;

  localparam int IN_W            = 16;
  localparam int ERR_W           = 10;
  localparam int DSAT_W          = 7;
  localparam int PTERM_W         = 10;
  localparam int DTERM_W         = 12;
  localparam int DTERM_COEFF_DEF = 7;

  typedef enum logic [1:0] {
    AX_PTCH = 2'd0,
    AX_ROLL = 2'd1,
    AX_YAW  = 2'd2
  } axis_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PTCH = 3'd1,
    ROLL = 3'd2,
    YAW  = 3'd3,
    DONE = 3'd4
  } sched_state_t;

  // Clamp the 17-bit raw error into -512..511.
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [IN_W:0] v);
    logic signed [ERR_W-1:0] r;
    if (v > 17'sd511) begin
      r = 10'sd511;
    end else if (v < -17'sd512) begin
      r = 10'sh200;
    end else begin
      r = v[ERR_W-1:0];
    end
    return r;
  endfunction

  // Clamp the D difference into -64..63.
  function automatic logic signed [DSAT_W-1:0] sat_dsat(input logic signed [ERR_W-1:0] v);
    logic signed [DSAT_W-1:0] r;
    if (v > 10'sd63) begin
      r = 7'sd63;
    end else if (v < -10'sd64) begin
      r = 7'sh40;
    end else begin
      r = v[DSAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pd_axis_sched_if.sv
// Sample/term bundle between the attitude source, the scheduler and the
// motor-mix logic. PD_OVR_CNT_EN adds the dropped-sample counter.
interface pd_axis_sched_if;
  import pd_pkg::*;

  logic                      vld;
  logic signed [IN_W-1:0]    ptch, roll, yaw;
  logic signed [IN_W-1:0]    d_ptch, d_roll, d_yaw;
  logic signed [PTERM_W-1:0] ptch_pterm, roll_pterm, yaw_pterm;
  logic signed [DTERM_W-1:0] ptch_dterm, roll_dterm, yaw_dterm;
  logic                      busy;
  logic                      done;
  logic                      ovr;
`ifdef PD_OVR_CNT_EN
  logic [7:0]                ovr_cnt;
`endif

  modport master (
    output vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    input  ptch_pterm, roll_pterm, yaw_pterm,
    input  ptch_dterm, roll_dterm, yaw_dterm,
`ifdef PD_OVR_CNT_EN
    input  ovr_cnt,
`endif
    input  busy, done, ovr
  );

  modport slave (
    input  vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw,
    output ptch_pterm, roll_pterm, yaw_pterm,
    output ptch_dterm, roll_dterm, yaw_dterm,
`ifdef PD_OVR_CNT_EN
    output ovr_cnt,
`endif
    output busy, done, ovr
  );

endinterface

// File: rtl/pd_core.sv
// Combinational PD arithmetic for one axis: saturated error, P term and D term
// against the oldest history sample.
module pd_core
  import pd_pkg::*;
#(
  parameter int DTERM_COEFF = DTERM_COEFF_DEF
) (
  input  logic signed [IN_W-1:0]    actual,
  input  logic signed [IN_W-1:0]    desired,
  input  logic signed [ERR_W-1:0]   oldest,
  output logic signed [ERR_W-1:0]   err_sat,
  output logic signed [PTERM_W-1:0] pterm,
  output logic signed [DTERM_W-1:0] dterm
);

  localparam logic signed [4:0] COEFF_S = 5'(DTERM_COEFF);

  logic signed [IN_W:0]     err_s;
  logic signed [ERR_W-1:0]  d_diff_s;
  logic signed [DSAT_W-1:0] d_sat_s;

  // Error, P and D datapath; the D difference wraps at 10 bits before clamping.
  always_comb begin
    err_s    = (IN_W+1)'(actual) - (IN_W+1)'(desired);
    err_sat  = sat_err(err_s);
    pterm    = (err_sat >>> 1) + (err_sat >>> 3);
    d_diff_s = err_sat - oldest;
    d_sat_s  = sat_dsat(d_diff_s);
    dterm    = DTERM_W'(d_sat_s) * DTERM_W'(COEFF_S);
  end

endmodule

// File: rtl/pd_axis_sched.sv
// Time-multiplexed PD scheduler: latches a three-axis attitude sample and runs
// pitch, roll, yaw through one shared pd_core, one axis per cycle.
// Optional macro PD_OVR_CNT_EN adds a saturating dropped-sample counter.
module pd_axis_sched
  import pd_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 12,
  parameter int DTERM_COEFF   = DTERM_COEFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pd_axis_sched_if.slave bus
);

  sched_state_t state_r, next_state_s;

  logic signed [IN_W-1:0]    act_r   [3];
  logic signed [IN_W-1:0]    des_r   [3];
  logic signed [ERR_W-1:0]   hist_r  [3][D_QUEUE_DEPTH];
  logic signed [PTERM_W-1:0] pterm_r [3];
  logic signed [DTERM_W-1:0] dterm_r [3];
  logic                      busy_r, done_r, ovr_r;

  logic [1:0]                sel_s;
  logic                      eval_s;
  logic                      drop_s;
  logic signed [ERR_W-1:0]   core_err_s;
  logic signed [PTERM_W-1:0] core_pterm_s;
  logic signed [DTERM_W-1:0] core_dterm_s;

  // Axis currently owning the shared core.
  always_comb begin
    sel_s  = 2'd0;
    eval_s = 1'b0;
    case (state_r)
      PTCH:    begin sel_s = AX_PTCH; eval_s = 1'b1; end
      ROLL:    begin sel_s = AX_ROLL; eval_s = 1'b1; end
      YAW:     begin sel_s = AX_YAW;  eval_s = 1'b1; end
      default: begin sel_s = 2'd0;    eval_s = 1'b0; end
    endcase
  end

  assign drop_s = bus.vld && (state_r != IDLE);

  pd_core #(.DTERM_COEFF(DTERM_COEFF)) u_core (
    .actual  (act_r[sel_s]),
    .desired (des_r[sel_s]),
    .oldest  (hist_r[sel_s][D_QUEUE_DEPTH-1]),
    .err_sat (core_err_s),
    .pterm   (core_pterm_s),
    .dterm   (core_dterm_s)
  );

  // Sequencer next-state: accept only from IDLE, then walk the three axes.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.vld) begin
          next_state_s = PTCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      PTCH:    next_state_s = ROLL;
      ROLL:    next_state_s = YAW;
      YAW:     next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      ovr_r   <= drop_s;
    end
  end

  // Input latch, per-axis term registers and per-axis D history shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 3; a++) begin
        act_r[a]   <= '0;
        des_r[a]   <= '0;
        pterm_r[a] <= '0;
        dterm_r[a] <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
          hist_r[a][i] <= '0;
        end
      end
    end else begin
      if ((state_r == IDLE) && bus.vld) begin
        act_r[0] <= bus.ptch;
        act_r[1] <= bus.roll;
        act_r[2] <= bus.yaw;
        des_r[0] <= bus.d_ptch;
        des_r[1] <= bus.d_roll;
        des_r[2] <= bus.d_yaw;
      end
      if (eval_s) begin
        pterm_r[sel_s]   <= core_pterm_s;
        dterm_r[sel_s]   <= core_dterm_s;
        hist_r[sel_s][0] <= core_err_s;
        for (int i = 1; i < D_QUEUE_DEPTH; i++) begin
          hist_r[sel_s][i] <= hist_r[sel_s][i-1];
        end
      end
    end
  end

`ifdef PD_OVR_CNT_EN
  logic [7:0] ovr_cnt_r;

  // Saturating count of samples dropped while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_r <= 8'd0;
    end else if (drop_s && (ovr_cnt_r != 8'hFF)) begin
      ovr_cnt_r <= ovr_cnt_r + 8'd1;
    end
  end

  assign bus.ovr_cnt = ovr_cnt_r;
`endif

  assign bus.ptch_pterm = pterm_r[0];
  assign bus.roll_pterm = pterm_r[1];
  assign bus.yaw_pterm  = pterm_r[2];
  assign bus.ptch_dterm = dterm_r[0];
  assign bus.roll_dterm = dterm_r[1];
  assign bus.yaw_dterm  = dterm_r[2];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ovr        = ovr_r;

endmodule

// File: tb/tb_pd_axis_sched.sv
// Self-checking bench for pd_axis_sched: fixed vector table, corner sequences
// and randomized samples against a queue-based reference model.
module tb_pd_axis_sched;
  import pd_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  pd_axis_sched_if bus();

  pd_axis_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int hq[3][$];
  int exp_pt[3];
  int exp_dt[3];

  typedef struct {
    int p, r, y, dp, dr, dy;
    int pp, rp, yp, pd, rd, yd;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      hq[a].delete();
      repeat (12) hq[a].push_back(0);
    end
  endtask

  task automatic model_eval(input int a, input int act, input int des,
                            output int pt, output int dt);
    int es, d;
    es = sat(act - des, -512, 511);
    pt = (es >>> 1) + (es >>> 3);
    d  = es - hq[a][0];
    d  = ((d + 512) & 1023) - 512;
    dt = sat(d, -64, 63) * 7;
    void'(hq[a].pop_front());
    hq[a].push_back(es);
  endtask

  function automatic int rv();
    logic [15:0] t;
    if ($urandom_range(0, 1) == 0) begin
      t = 16'($urandom);
      return int'($signed(t));
    end
    return int'($urandom_range(0, 1400)) - 700;
  endfunction

  task automatic drive_inputs(input int p, input int r, input int y,
                              input int dp, input int dr, input int dy);
    bus.ptch   = 16'(p);
    bus.roll   = 16'(r);
    bus.yaw    = 16'(y);
    bus.d_ptch = 16'(dp);
    bus.d_roll = 16'(dr);
    bus.d_yaw  = 16'(dy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.vld = 1'b0;
    drive_inputs(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_terms(input string tag);
    chk({tag, "_ptch_pterm"}, int'(bus.ptch_pterm), exp_pt[0]);
    chk({tag, "_roll_pterm"}, int'(bus.roll_pterm), exp_pt[1]);
    chk({tag, "_yaw_pterm"},  int'(bus.yaw_pterm),  exp_pt[2]);
    chk({tag, "_ptch_dterm"}, int'(bus.ptch_dterm), exp_dt[0]);
    chk({tag, "_roll_dterm"}, int'(bus.roll_dterm), exp_dt[1]);
    chk({tag, "_yaw_dterm"},  int'(bus.yaw_dterm),  exp_dt[2]);
  endtask

  // Present one sample from IDLE, optionally re-assert vld before edge ovr_at
  // (1..4), check the cycle-exact busy/done/ovr timing, then advance the model.
  task automatic send(input int p, input int r, input int y,
                      input int dp, input int dr, input int dy,
                      input int ovr_at, input bit use_model);
    int acts[3];
    int dess[3];
    int pt, dt;
    acts = '{p, r, y};
    dess = '{dp, dr, dy};
    @(negedge clk);
    bus.vld = 1'b1;
    drive_inputs(p, r, y, dp, dr, dy);
    @(posedge clk); #1;
    chk("busy_after_accept", int'(bus.busy), 1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      bus.vld = (cyc == ovr_at);
      drive_inputs(rv(), rv(), rv(), rv(), rv(), rv());
      @(posedge clk); #1;
      chk("done_timing", int'(bus.done), int'(cyc == 3));
      chk("ovr_timing",  int'(bus.ovr),  int'(cyc == ovr_at));
    end
    bus.vld = 1'b0;
    chk("busy_after_done", int'(bus.busy), 0);
    for (int a = 0; a < 3; a++) begin
      model_eval(a, acts[a], dess[a], pt, dt);
      exp_pt[a] = pt;
      exp_dt[a] = dt;
    end
    if (use_model) check_terms("model");
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.vld = 1'b0;
    drive_inputs(0, 0, 0, 0, 0, 0);
    model_reset();

    tbl[0] = '{100, 0, 0, 0, 0, 0,           62, 0, 0,      441, 0, 0};
    tbl[1] = '{0, -2000, 0, 0, 0, 0,         0, -320, 0,    0, -448, 0};
    tbl[2] = '{-100, 0, 600, -50, 0, 0,      -32, 0, 318,   -350, 0, 441};
    tbl[3] = '{5, 30000, -7, -3, -30000, 0,  5, 318, -5,    56, 441, -49};

    #12;
    chk("rst_ptch_pterm", int'(bus.ptch_pterm), 0);
    chk("rst_yaw_dterm",  int'(bus.yaw_dterm),  0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_done",       int'(bus.done),       0);
    chk("rst_ovr",        int'(bus.ovr),        0);
    do_reset();

    // Fixed vectors applied back to back from reset.
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].p, tbl[i].r, tbl[i].y, tbl[i].dp, tbl[i].dr, tbl[i].dy, 0, 1'b0);
      exp_pt = '{tbl[i].pp, tbl[i].rp, tbl[i].yp};
      exp_dt = '{tbl[i].pd, tbl[i].rd, tbl[i].yd};
      check_terms("table");
    end

    // Queue depth: the 13th identical yaw sample sees its own first copy.
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      send(0, 0, 100, 0, 0, 0, 0, 1'b0);
      chk("yaw_dterm_depth", int'(bus.yaw_dterm), (k < 13) ? 441 : 0);
    end

    // Overrun at E2: dropped sample, single done, first sample's results.
    do_reset();
    send(100, 0, 0, 0, 0, 0, 2, 1'b0);
    chk("ovr_ptch_pterm", int'(bus.ptch_pterm), 62);
    chk("ovr_ptch_dterm", int'(bus.ptch_dterm), 441);
    @(posedge clk); #1;
    chk("ovr_no_second_sample", int'(bus.busy), 0);
`ifdef PD_OVR_CNT_EN
    chk("ovr_cnt_one", int'(bus.ovr_cnt), 1);
`endif

    // Reset while ROLL is being evaluated.
    do_reset();
    @(negedge clk);
    bus.vld = 1'b1;
    drive_inputs(100, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.vld = 1'b0;
    @(posedge clk); #1;
    chk("mid_ptch_written", int'(bus.ptch_pterm), 62);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ptch_pterm", int'(bus.ptch_pterm), 0);
    chk("mid_rst_ptch_dterm", int'(bus.ptch_dterm), 0);
    chk("mid_rst_busy",       int'(bus.busy),       0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", int'(bus.done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send(100, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("mid_rst_hist_cleared", int'(bus.ptch_dterm), 441);

    // Randomized samples with occasional overruns, checked against the model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int oa;
      oa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      send(rv(), rv(), rv(), rv(), rv(), rv(), oa, 1'b1);
    end

`ifdef PD_OVR_CNT_EN
    // Continuous vld: four drops per accepted sample, well past 255.
    do_reset();
    @(negedge clk);
    bus.vld = 1'b1;
    repeat (400) @(negedge clk);
    bus.vld = 1'b0;
    @(posedge clk); #1;
    chk("ovr_cnt_saturate", int'(bus.ovr_cnt), 255);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
